// File: rtl/fir_output_stage.sv
// FIR output stage: registers the last tap's sum, rounds/saturates it to OUT_W bits and
// queues results in a small FIFO drained by valid/ready. Counts saturations and drops.
module fir_output_stage #(
   parameter int N     = 32,
   parameter int OUT_W = 16,
   parameter int SHIFT = 8,
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       ena,
   input  logic signed [N-1:0]        y_in,
   output logic signed [OUT_W-1:0]    out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     level,
   output logic [CNT_W-1:0]           sat_cnt,
   output logic [CNT_W-1:0]           drop_cnt
);
   localparam int AW  = $clog2(DEPTH);
   localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic signed [N:0] RND     = (SHIFT > 0) ? ((N+1)'(1) <<< RSH) : '0;
   localparam logic signed [N:0] SAT_MAX = {{(N+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [N:0] SAT_MIN = {{(N+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

   logic signed [N-1:0]                s1_data_q;
   logic                               s1_valid_q;
   logic signed [N:0]                  t, r;
   logic signed [OUT_W-1:0]            word;
   logic                               sat;
   logic [DEPTH-1:0][OUT_W-1:0]        mem_q;
   logic [OUT_W-1:0]                   last_q;
   logic [AW:0]                        wr_q, wr_d, rd_q, rd_d;
   logic [CNT_W-1:0]                   sat_q, sat_d, drop_q, drop_d;
   logic                               empty, full, pop, push, drop;

   // Stage 2: round half up in N+1 bits so the rounding add can never overflow.
   always_comb begin
      t    = {s1_data_q[N-1], s1_data_q} + RND;
      r    = t >>> SHIFT;
      word = r[OUT_W-1:0];
      sat  = 1'b0;
      if (r > SAT_MAX) begin
         word = SAT_MAX[OUT_W-1:0];
         sat  = 1'b1;
      end else if (r < SAT_MIN) begin
         word = SAT_MIN[OUT_W-1:0];
         sat  = 1'b1;
      end
   end

   assign empty = (wr_q == rd_q);
   assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign pop   = !empty && out_ready;
   // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
   assign push  = s1_valid_q && (!full || pop);
   assign drop  = s1_valid_q && full && !pop;

   always_comb begin
      wr_d   = push ? wr_q + 1'b1 : wr_q;
      rd_d   = pop  ? rd_q + 1'b1 : rd_q;
      sat_d  = (s1_valid_q && sat && sat_q != '1) ? sat_q + 1'b1 : sat_q;
      drop_d = (drop && drop_q != '1) ? drop_q + 1'b1 : drop_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_data_q  <= '0;
         s1_valid_q <= 1'b0;
         mem_q      <= '0;
         last_q     <= '0;
         wr_q       <= '0;
         rd_q       <= '0;
         sat_q      <= '0;
         drop_q     <= '0;
      end else begin
         s1_valid_q <= ena;
         if (ena) s1_data_q <= y_in;
         if (push) mem_q[wr_q[AW-1:0]] <= word;
         // Remember the popped head so out_data holds it once the FIFO runs dry.
         if (pop) last_q <= mem_q[rd_q[AW-1:0]];
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         sat_q  <= sat_d;
         drop_q <= drop_d;
      end
   end

   assign out_valid = !empty;
   assign out_data  = empty ? last_q : mem_q[rd_q[AW-1:0]];
   assign level     = wr_q - rd_q;
   assign sat_cnt   = sat_q;
   assign drop_cnt  = drop_q;
endmodule

// File: tb/tb_fir_output_stage.sv
// Bench for fir_output_stage: constant vectors, directed FIFO corner sequences and random
// traffic, all checked each cycle against a queue-based reference model.
module tb_fir_output_stage;
   localparam int N = 32, OUT_W = 16, SHIFT = 8, DEPTH = 4, CNT_W = 16;

   logic               clk = 1'b0;
   logic               rst, ena, out_ready, out_valid;
   logic [N-1:0]       y_in;
   logic [OUT_W-1:0]   out_data;
   logic [2:0]         level;
   logic [CNT_W-1:0]   sat_cnt, drop_cnt;

   fir_output_stage #(.N(N), .OUT_W(OUT_W), .SHIFT(SHIFT), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .ena(ena), .y_in(y_in), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .level(level), .sat_cnt(sat_cnt), .drop_cnt(drop_cnt));

   always #5 clk = ~clk;

   int n_tests = 0, n_fail = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a plain queue of words plus integer counters.
   bit               m_s1v;
   longint           m_s1d;
   logic [OUT_W-1:0] q[$];
   logic [OUT_W-1:0] m_last;
   int               m_sat, m_drop;

   function automatic logic [OUT_W-1:0] round_sat(input longint v, output bit s);
      longint half, hi, lo, rr;
      half = (SHIFT > 0) ? (longint'(1) << (SHIFT - 1)) : 0;
      hi   = (longint'(1) << (OUT_W - 1)) - 1;
      lo   = -(longint'(1) << (OUT_W - 1));
      rr   = (v + half) >>> SHIFT;
      s    = 1'b0;
      if (rr > hi) begin rr = hi; s = 1'b1; end
      else if (rr < lo) begin rr = lo; s = 1'b1; end
      return OUT_W'(rr);
   endfunction

   task automatic model_reset();
      m_s1v = 0; m_s1d = 0; q.delete(); m_last = '0; m_sat = 0; m_drop = 0;
   endtask

   task automatic model_edge();
      bit s;
      logic [OUT_W-1:0] w;
      if (q.size() > 0 && out_ready) m_last = q.pop_front();
      if (m_s1v) begin
         w = round_sat(m_s1d, s);
         if (s && m_sat < 65535) m_sat++;
         if (q.size() < DEPTH) q.push_back(w);
         else if (m_drop < 65535) m_drop++;
      end
      m_s1v = ena;
      m_s1d = longint'($signed(y_in));
   endtask

   task automatic check_all();
      chk("out_valid", out_valid, q.size() > 0);
      chk("level", level, q.size());
      chk("out_data", out_data, (q.size() > 0) ? q[0] : m_last);
      chk("sat_cnt", sat_cnt, m_sat);
      chk("drop_cnt", drop_cnt, m_drop);
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      check_all();
   endtask

   typedef struct { logic [N-1:0] y; logic [OUT_W-1:0] exp; } vec_t;
   vec_t tbl[8];

   initial begin
      tbl[0] = '{32'h0000_1280, 16'h0013};
      tbl[1] = '{32'hFFFF_FE80, 16'hFFFF};
      tbl[2] = '{32'h0000_007F, 16'h0000};
      tbl[3] = '{32'h0000_0080, 16'h0001};
      tbl[4] = '{32'hFFFF_FF7F, 16'hFFFF};
      tbl[5] = '{32'hFFFF_FF80, 16'h0000};
      tbl[6] = '{32'h7FFF_FFFF, 16'h7FFF};
      tbl[7] = '{32'h8000_0000, 16'h8000};

      rst = 1'b0; ena = 1'b0; out_ready = 1'b0; y_in = '0;
      model_reset();
      #12;
      chk("rst_valid", out_valid, 0);
      chk("rst_level", level, 0);
      chk("rst_data", out_data, 0);
      chk("rst_sat", sat_cnt, 0);
      chk("rst_drop", drop_cnt, 0);
      rst = 1'b1;

      // Rounding/saturation vectors: one strobe each, head visible after two edges, popped on the third.
      out_ready = 1'b1;
      foreach (tbl[i]) begin
         ena = 1'b1; y_in = tbl[i].y;
         step();
         ena = 1'b0;
         step();
         chk("vec_valid", out_valid, 1);
         chk("vec_data", out_data, tbl[i].exp);
         step();
         chk("vec_popped", out_valid, 0);
         chk("vec_hold", out_data, tbl[i].exp);
      end
      chk("vec_sat_cnt", sat_cnt, 2);

      // Overfill with consumer stalled: the last two samples are dropped.
      out_ready = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         ena = 1'b1; y_in = N'(i << 8);
         step();
      end
      ena = 1'b0;
      step();
      chk("fill_level", level, 4);
      chk("fill_drop", drop_cnt, 2);
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         chk("drain_data", out_data, i);
         step();
      end
      chk("drain_empty", out_valid, 0);

      // Push and pop on the same edge while full: no drop, order preserved.
      out_ready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         ena = 1'b1; y_in = N'(i << 8);
         step();
      end
      chk("full_level", level, 4);
      ena = 1'b0; out_ready = 1'b1;
      step();
      chk("pp_level", level, 4);
      chk("pp_drop", drop_cnt, 2);
      for (int i = 2; i <= 5; i++) begin
         chk("pp_order", out_data, i);
         step();
      end

      // Random traffic against the model.
      for (int c = 0; c < 400; c++) begin
         ena       = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         case ($urandom_range(0, 2))
            0:       y_in = N'($urandom_range(0, 16'hFFFF)) - 32'h8000;
            1:       y_in = N'($urandom_range(0, 32'h00FF_FFFF)) - 32'h0080_0000;
            default: y_in = $urandom();
         endcase
         step();
      end

      // Build level 3, then pulse reset asynchronously between edges.
      ena = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < DEPTH + 2; i++) step();
      out_ready = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         ena = 1'b1; y_in = N'(i << 8);
         step();
      end
      ena = 1'b0;
      step();
      chk("pre_rst_level", level, 3);
      #2 rst = 1'b0;
      #1;
      chk("arst_valid", out_valid, 0);
      chk("arst_level", level, 0);
      chk("arst_sat", sat_cnt, 0);
      chk("arst_drop", drop_cnt, 0);
      chk("arst_data", out_data, 0);
      model_reset();
      #2 rst = 1'b1;
      out_ready = 1'b1; ena = 1'b1; y_in = 32'h0000_0180;
      step();
      ena = 1'b0;
      step();
      chk("post_rst_data", out_data, 16'h0002);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
